// File: rtl/spi_pixel_sender_if.sv
// spi_pixel_sender_if: pixel-word handshake plus SPI pin bundle for spi_pixel_sender
interface spi_pixel_sender_if #(parameter int W = 24);
   logic [W-1:0] WordIn;
   logic         WordValid;
   logic         WordReady;
   logic         Busy;
   logic         Sclk;
   logic         Mosi;
   logic         CSel;
   modport master (output WordIn, WordValid, input WordReady, Busy, Sclk, Mosi, CSel);
   modport slave (input WordIn, WordValid, output WordReady, Busy, Sclk, Mosi, CSel);
endinterface

// File: rtl/spi_pixel_sender.sv
// spi_pixel_sender: mode-0 SPI master sending each pixel word as CSel-framed bytes, MSB first
// Define SPI_TX_FIFO_EN to put a FIFO_DEPTH-word FIFO in front of the FSM; otherwise a single holding register.
module spi_pixel_sender #(
   parameter int CLK_DIV        = 1,
   parameter int BYTES_PER_WORD = 3,
   parameter int PACKET_GAP     = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input logic               MainClkSrc,
   input logic               Reset,
   spi_pixel_sender_if.slave bus
);
   localparam int W  = 8 * BYTES_PER_WORD;
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int YW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
   localparam int GW = PACKET_GAP > 1 ? $clog2(PACKET_GAP) : 1;
   typedef enum logic [2:0] {IDLE, SETUP, BIT_LO, BIT_HI, TAIL, DESEL, GAP} state_t;
   state_t        state_q;
   logic [DW-1:0] div_q;
   logic [2:0]    bit_q;
   logic [YW-1:0] byte_q;
   logic [GW-1:0] gap_q;
   logic [7:0]    shreg_q;
   logic [W-1:0]  word_q;
   logic          sclk_q, mosi_q, csel_q;
   logic          avail;
   logic [W-1:0]  head;
   logic          tick;
   assign tick     = div_q == DW'(CLK_DIV - 1);
   assign bus.Sclk = sclk_q;
   assign bus.Mosi = mosi_q;
   assign bus.CSel = csel_q;
`ifdef SPI_TX_FIFO_EN
   localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   logic [W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          push, pop;
   assign bus.WordReady = cnt_q != (AW + 1)'(FIFO_DEPTH);
   assign bus.Busy      = state_q != IDLE || cnt_q != '0;
   assign push          = bus.WordValid && bus.WordReady;
   assign pop           = state_q == IDLE && cnt_q != '0;
   assign avail         = pop;
   assign head          = mem_q[rd_q];
   // word storage; only occupied slots are ever read, so no reset is needed
   always_ff @(posedge MainClkSrc)
      if (push) mem_q[wr_q] <= bus.WordIn;
   // pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge MainClkSrc or posedge Reset)
      if (Reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_q + AW'(1);
         if (pop) rd_q <= rd_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_q + AW'(1);
         cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end
`else
   assign bus.WordReady = state_q == IDLE;
   assign bus.Busy      = state_q != IDLE;
   assign avail         = bus.WordValid;
   assign head          = bus.WordIn;
`endif
   // byte/bit sequencer with registered SPI pins; the word register shifts out one byte per frame
   always_ff @(posedge MainClkSrc or posedge Reset)
      if (Reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         gap_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         csel_q  <= 1'b1;
      end else begin
         div_q <= (state_q == IDLE || state_q == GAP || tick) ? '0 : div_q + DW'(1);
         case (state_q)
            IDLE: if (avail) begin
               state_q <= SETUP;
               csel_q  <= 1'b0;
               shreg_q <= head[W-1 -: 8];
               word_q  <= head << 8;
            end
            SETUP: if (tick) begin
               state_q <= BIT_LO;
               mosi_q  <= shreg_q[7];
            end
            BIT_LO: if (tick) begin
               state_q <= BIT_HI;
               sclk_q  <= 1'b1;
            end
            BIT_HI: if (tick) begin
               sclk_q  <= 1'b0;
               shreg_q <= shreg_q << 1;
               bit_q   <= bit_q + 3'd1;
               state_q <= bit_q == 3'd7 ? TAIL : BIT_LO;
               if (bit_q != 3'd7) mosi_q <= shreg_q[6];
            end
            TAIL: if (tick) begin
               state_q <= DESEL;
               csel_q  <= 1'b1;
               mosi_q  <= 1'b0;
            end
            DESEL: if (tick) begin
               if (byte_q == YW'(BYTES_PER_WORD - 1)) begin
                  byte_q  <= '0;
                  state_q <= PACKET_GAP == 0 ? IDLE : GAP;
               end else begin
                  byte_q  <= byte_q + YW'(1);
                  state_q <= SETUP;
                  csel_q  <= 1'b0;
                  shreg_q <= word_q[W-1 -: 8];
                  word_q  <= word_q << 8;
               end
            end
            GAP: begin
               gap_q <= gap_q == GW'(PACKET_GAP - 1) ? '0 : gap_q + GW'(1);
               if (gap_q == GW'(PACKET_GAP - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_pixel_sender.sv
// tb_spi_pixel_sender: randomized bench with a byte-level SPI receiver and word-to-byte reference model
module tb_spi_pixel_sender;
   localparam int BPW = 3;
   localparam int W   = 8 * BPW;
   localparam int CD0 = 1;
   localparam int CD1 = 4;
   localparam int PG0 = 16;
   localparam int PG1 = 0;
`ifdef SPI_TX_FIFO_EN
   localparam int FQ   = 1;
   localparam int ACC6 = 5;
`else
   localparam int FQ   = 0;
   localparam int ACC6 = 1;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   always #5 clk = ~clk;
   spi_pixel_sender_if #(.W(W)) a_if ();
   spi_pixel_sender_if #(.W(W)) b_if ();
   spi_pixel_sender #(.CLK_DIV(CD0), .BYTES_PER_WORD(BPW), .PACKET_GAP(PG0), .FIFO_DEPTH(4)) dut_a (
      .MainClkSrc(clk), .Reset(rst), .bus(a_if.slave));
   spi_pixel_sender #(.CLK_DIV(CD1), .BYTES_PER_WORD(BPW), .PACKET_GAP(PG1), .FIFO_DEPTH(4)) dut_b (
      .MainClkSrc(clk), .Reset(rst), .bus(b_if.slave));
   logic [1:0] sclk, mosi, csel, busy, rdy;
   logic [1:0] sclk_p, mosi_p, csel_p, busy_p;
   assign sclk = {b_if.Sclk, a_if.Sclk};
   assign mosi = {b_if.Mosi, a_if.Mosi};
   assign csel = {b_if.CSel, a_if.CSel};
   assign busy = {b_if.Busy, a_if.Busy};
   assign rdy  = {b_if.WordReady, a_if.WordReady};
   logic [7:0] sh [2];
   logic [7:0] rx [2][256];
   int         gaps [2][64];
   int         nb [2], hi_run [2], lo_run [2], cs_run [2], bz_run [2];
   int         last_busy [2], viol [2], rxn [2], gn [2];
   logic [7:0] ex [2][256];
   int         exn [2], erd [2], rd [2];
   function automatic int cd(input int i);
      return i == 0 ? CD0 : CD1;
   endfunction
   function automatic int wtime(input int i);
      return BPW * 19 * cd(i) + (i == 0 ? PG0 : PG1) + FQ;
   endfunction
   // SPI receiver: captures a byte per CSel-low frame and flags any pin-timing breach
   always @(posedge clk)
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            nb[i]     <= 0;
            hi_run[i] <= 0;
            lo_run[i] <= 0;
         end else begin
            if (!csel[i] && sclk[i] && !sclk_p[i]) begin
               sh[i] <= {sh[i][6:0], mosi[i]};
               nb[i] <= nb[i] + 1;
               if (lo_run[i] != (nb[i] == 0 ? 2 * cd(i) : cd(i))) viol[i] <= viol[i] + 1;
            end
            if (!sclk[i] && sclk_p[i] && hi_run[i] != cd(i)) viol[i] <= viol[i] + 1;
            if ((csel[i] && (sclk[i] || mosi[i])) || (sclk[i] && sclk_p[i] && mosi[i] != mosi_p[i]))
               viol[i] <= viol[i] + 1;
            if (csel[i] && !csel_p[i]) begin
               nb[i] <= 0;
               if (nb[i] == 8) begin
                  rx[i][rxn[i] % 256] <= sh[i];
                  rxn[i] <= rxn[i] + 1;
               end else viol[i] <= viol[i] + 1;
            end
            if (!csel[i] && csel_p[i]) begin
               gaps[i][gn[i] % 64] <= cs_run[i];
               gn[i] <= gn[i] + 1;
            end
            hi_run[i] <= sclk[i] ? hi_run[i] + 1 : 0;
            lo_run[i] <= (csel[i] || sclk[i]) ? 0 : lo_run[i] + 1;
         end
         cs_run[i] <= csel[i] ? cs_run[i] + 1 : 0;
         bz_run[i] <= busy[i] ? bz_run[i] + 1 : 0;
         if (!busy[i] && busy_p[i]) last_busy[i] <= bz_run[i];
         sclk_p[i] <= sclk[i];
         mosi_p[i] <= mosi[i];
         csel_p[i] <= csel[i];
         busy_p[i] <= busy[i];
      end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input int i, input logic v, input logic [W-1:0] w);
      if (i == 0) begin
         a_if.WordValid = v;
         a_if.WordIn    = w;
      end else begin
         b_if.WordValid = v;
         b_if.WordIn    = w;
      end
   endtask
   task automatic expect_word(input int i, input logic [W-1:0] w);
      for (int k = 0; k < BPW; k++) begin
         ex[i][exn[i] % 256] = 8'(w >> (8 * (BPW - 1 - k)));
         exn[i]++;
      end
   endtask
   task automatic offer(input int i, input logic [W-1:0] w, input int lim);
      int n;
      n = 0;
      drive(i, 1'b1, w);
      while (!rdy[i] && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("accept in time", 32'(n < lim), 1);
      if (n < lim) expect_word(i, w);
      @(negedge clk);
   endtask
   task automatic wait_idle(input int i, input int lim);
      int n;
      n = 0;
      while (busy[i] && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("idle in time", 32'(n < lim), 1);
      repeat (2) @(negedge clk);
   endtask
   task automatic check_rx(input int i);
      check("rx byte count", rxn[i] - rd[i], exn[i] - erd[i]);
      while (rd[i] < rxn[i] && erd[i] < exn[i]) begin
         check("rx byte", rx[i][rd[i] % 256], ex[i][erd[i] % 256]);
         rd[i]++;
         erd[i]++;
      end
      rd[i]  = rxn[i];
      erd[i] = exn[i];
      check("pin timing violations", viol[i], 0);
   endtask
   task automatic check_idle(input int i);
      check("CSel idle", csel[i], 1);
      check("Sclk idle", sclk[i], 0);
      check("Mosi idle", mosi[i], 0);
      check("Busy idle", busy[i], 0);
      check("WordReady idle", rdy[i], 1);
   endtask
   initial begin
      int acc, k, n, g0;
      logic [W-1:0] w;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      repeat (3) @(negedge clk);
      check_idle(0);
      check_idle(1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle(0);
      check_idle(1);
      offer(0, 24'hC0C0C0, 4);
      drive(0, 1'b0, '0);
      wait_idle(0, 300);
      check_rx(0);
      check("busy length C0C0C0", last_busy[0], wtime(0));
      g0 = gn[0];
      offer(0, 24'hC0C0C0, 4);
      offer(0, 24'h030303, 300);
`ifndef SPI_TX_FIFO_EN
      check("word1 done before word2 accepted", rxn[0] - rd[0], BPW);
`endif
      drive(0, 1'b0, '0);
      wait_idle(0, 300);
      check("inter-word CSel gap", 32'(gaps[0][(g0 + BPW) % 64] >= PG0), 1);
      check_rx(0);
      offer(0, 24'($urandom), 4);
      drive(0, 1'b0, '0);
      k = 0;
      n = 0;
      while (k < 3 && n < 100) begin
         @(negedge clk);
         n++;
         if (sclk[0]) k++;
      end
      check("third Sclk rise seen", k, 3);
      #1 rst = 1'b1;
      #1;
      check("async reset CSel", csel[0], 1);
      check("async reset Sclk", sclk[0], 0);
      check("async reset Mosi", mosi[0], 0);
      repeat (2) @(negedge clk);
      check_idle(0);
      rst = 1'b0;
      rd[0]  = rxn[0];
      erd[0] = exn[0];
      @(negedge clk);
      offer(0, 24'($urandom), 4);
      drive(0, 1'b0, '0);
      wait_idle(0, 300);
      check_rx(0);
      offer(1, 24'hA5A5A5, 4);
      drive(1, 1'b0, '0);
      wait_idle(1, 1000);
      check_rx(1);
      check("busy length CLK_DIV=4", last_busy[1], wtime(1));
      for (int t = 0; t < 12; t++) begin
         w = 24'($urandom);
         offer(t % 2, w, 2000);
         drive(t % 2, 1'b0, 24'($urandom));
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_idle(0, 2000);
      wait_idle(1, 2000);
      check_rx(0);
      check_rx(1);
      acc = 0;
      for (int t = 0; t < 6; t++) begin
         w = 24'($urandom);
         drive(0, 1'b1, w);
         if (rdy[0]) begin
            acc++;
            expect_word(0, w);
         end
         @(negedge clk);
      end
      drive(0, 1'b0, '0);
      check("burst words accepted", acc, ACC6);
      wait_idle(0, 2000);
      check_rx(0);
      check_idle(0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
